// File: rtl/pp_pkg.sv
// Shared types and constants for the MEM pipeline stage.
//   mem_state_t     : memory-access FSM states (IDLE, WAIT)
//   MEM_TIMEOUT_DEF : default number of WAIT cycles before an access is aborted
//   CNT_W           : width of the timeout counter (covers MEM_TIMEOUT 1..15)
//   is_aligned()    : word-alignment test on the low address bits
package pp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   localparam int MEM_TIMEOUT_DEF = 15;
   localparam int CNT_W           = 4;

   function automatic logic is_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wb_flopr.sv
// MEM/WB pipeline register.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   bubble_i        : load an empty slot (result 0, dst 0, no write-back)
//   result_i/dst_i/wreg_i : next MEM/WB contents when not bubbling
//   result_o/dst_o/wreg_o : registered MEM/WB contents
module mem_wb_flopr #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             bubble_i,
   input  logic [WIDTH-1:0] result_i,
   input  logic [4:0]       dst_i,
   input  logic             wreg_i,
   output logic [WIDTH-1:0] result_o,
   output logic [4:0]       dst_o,
   output logic             wreg_o
);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         result_o <= '0;
         dst_o    <= '0;
         wreg_o   <= 1'b0;
      end else if (bubble_i) begin
         result_o <= '0;
         dst_o    <= '0;
         wreg_o   <= 1'b0;
      end else begin
         result_o <= result_i;
         dst_o    <= dst_i;
         wreg_o   <= wreg_i;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-memory requests for loads/stores, stalls
// the front of the pipe while waiting for an ack, aborts on timeout, and
// drives the MEM/WB register.
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   alu_out_im32 ...         : EX/MEM register contents (address/ALU result,
//                              store data, destination, controls)
//   dmem_req_o/we_o/addr/wdata : data-memory request side
//   dmem_rdata_i32, dmem_ack_i : data-memory response side
//   stall_o                  : freezes PC, IF/ID, ID/EX, EX/MEM
//   result_ow32, dst_reg_addr_ow5, enable_wreg_ow : MEM/WB outputs
//   mem_err_o                : sticky misalignment/timeout flag
module mem_stage_ctrl
   import pp_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic [WIDTH-1:0] alu_out_im32,
   input  logic [WIDTH-1:0] write_data_im32,
   input  logic [4:0]       dst_reg_addr_im5,
   input  logic             enable_wreg_im,
   input  logic             mem_to_reg_im,
   input  logic             enable_wmem_im,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic [WIDTH-1:0] dmem_addr_o32,
   output logic [WIDTH-1:0] dmem_wdata_o32,
   input  logic [WIDTH-1:0] dmem_rdata_i32,
   input  logic             dmem_ack_i,
   output logic             stall_o,
   output logic [WIDTH-1:0] result_ow32,
   output logic [4:0]       dst_reg_addr_ow5,
   output logic             enable_wreg_ow,
   output logic             mem_err_o
);

   // Last WAIT count value before abort: the MEM_TIMEOUT-th WAIT cycle
   // without an ack is the abort cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   mem_state_t       state;
   logic [CNT_W-1:0] cnt;

   logic mem_op, aligned;
   logic req, stall, misal, abort, bubble;

   assign mem_op  = mem_to_reg_im | enable_wmem_im;
   assign aligned = is_aligned(alu_out_im32[1:0]);

   // Request/stall are combinational so the memory sees the access in the
   // same cycle; gated by reset so an access is dropped the instant reset
   // asserts. Ack only counts while a request is outstanding.
   always_comb begin
      req   = 1'b0;
      stall = 1'b0;
      misal = 1'b0;
      abort = 1'b0;
      if (reset_ni) begin
         unique case (state)
            IDLE: begin
               if (mem_op) begin
                  if (!aligned) begin
                     misal = 1'b1;
                  end else begin
                     req   = 1'b1;
                     stall = !dmem_ack_i;
                  end
               end
            end
            WAIT: begin
               req = 1'b1;
               if (!dmem_ack_i) begin
                  // ack on the timeout cycle wins (checked first above)
                  if (cnt == CNT_LAST) abort = 1'b1;
                  else                 stall = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem_req_o     = req;
   assign dmem_we_o      = req & enable_wmem_im;
   assign dmem_addr_o32  = alu_out_im32;
   assign dmem_wdata_o32 = write_data_im32;
   assign stall_o        = stall;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state     <= IDLE;
         cnt       <= '0;
         mem_err_o <= 1'b0;
      end else begin
         if (misal || abort) mem_err_o <= 1'b1;
         unique case (state)
            IDLE: begin
               if (req && !dmem_ack_i) begin
                  state <= WAIT;
                  cnt   <= '0;
               end
            end
            WAIT: begin
               if (dmem_ack_i || abort) state <= IDLE;
               else                     cnt   <= cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stalled edges, misaligned ops and aborts all write an empty MEM/WB slot
   // so the held instruction is written back exactly once.
   assign bubble = stall | misal | abort;

   mem_wb_flopr #(.WIDTH(WIDTH)) u_mem_wb (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .bubble_i (bubble),
      .result_i (mem_to_reg_im ? dmem_rdata_i32 : alu_out_im32),
      .dst_i    (dst_reg_addr_im5),
      .wreg_i   (enable_wreg_im),
      .result_o (result_ow32),
      .dst_o    (dst_reg_addr_ow5),
      .wreg_o   (enable_wreg_ow)
   );

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, max WAIT cycles before abort (range 1..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_i  in  1  clock; all state on rising edge.
REQ-005 reset_ni  in  1  asynchronous active-low reset.
REQ-006 alu_out_im32  in  WIDTH  ALU result from EX/MEM register; load/store byte address.
REQ-007 write_data_im32  in  WIDTH  store data from EX/MEM register.
REQ-008 dst_reg_addr_im5  in  5  destination register.
REQ-009 enable_wreg_im / mem_to_reg_im / enable_wmem_im  in  1 each  write-reg, load, store controls.
REQ-010 dmem_req_o  out  1  data-memory request, held until ack.
REQ-011 dmem_we_o  out  1  store when high; valid while dmem_req_o=1.
REQ-012 dmem_addr_o32 / dmem_wdata_o32  out  WIDTH each  equal alu_out_im32 / write_data_im32.
REQ-013 dmem_rdata_i32  in  WIDTH  load data, valid in the cycle dmem_ack_i=1.
REQ-014 dmem_ack_i  in  1  memory completion strobe.
REQ-015 stall_o  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM while high.
REQ-016 result_ow32  out  WIDTH  MEM/WB result (load data or ALU result).
REQ-017 dst_reg_addr_ow5 / enable_wreg_ow  out  5 / 1  MEM/WB destination and write enable.
REQ-018 mem_err_o  out  1  sticky flag: misaligned access or timeout.

Function
REQ-019 mem_op = mem_to_reg_im | enable_wmem_im; FSM states IDLE, WAIT.
REQ-020 Non-mem op in IDLE: stall_o=0, no request; next edge loads MEM/WB with alu_out_im32, dst, enable_wreg_im (1-cycle latency).
REQ-021 Mem op with alu_out_im32[1:0]!=0: no request, stall_o=0, next edge sets mem_err_o and loads bubble (enable_wreg_ow=0).
REQ-022 Aligned mem op in IDLE: dmem_req_o=1, dmem_we_o=enable_wmem_im in the same cycle.
REQ-023 IDLE with ack high: complete that cycle, stall_o=0, stay IDLE.
REQ-024 IDLE with ack low: stall_o=1, go to WAIT, timeout counter cleared to 0.
REQ-025 WAIT: dmem_req_o=1, stall_o=1 until ack; counter increments each non-ack cycle.
REQ-026 WAIT with ack high: stall_o=0, complete, return to IDLE.
REQ-027 Completion: result_ow32 = dmem_rdata_i32 if load, else alu_out_im32; dst/enable_wreg from inputs.
REQ-028 Every stalled edge SHALL load a bubble into MEM/WB (enable_wreg_ow=0, result 0) so no register is written twice.
REQ-029 Counter reaching MEM_TIMEOUT in WAIT without ack: abort, stall_o=0, set mem_err_o, load bubble, go to IDLE.
REQ-030 Ack on the timeout cycle: the ack wins and the access completes normally.
REQ-031 dmem_ack_i while dmem_req_o=0 SHALL be ignored.
REQ-032 mem_err_o clears only on reset.

Reset
REQ-033 reset_ni low: state IDLE, counter 0, result_ow32 0, dst_reg_addr_ow5 0, enable_wreg_ow 0, mem_err_o 0, dmem_req_o 0, stall_o 0, immediately and asynchronously.
REQ-034 Reset during WAIT SHALL drop dmem_req_o in the same cycle and abandon the access without a write-back.

Structure
REQ-035 Package pp_pkg SHALL hold the mem_state_t enum (IDLE, WAIT) and the default MEM_TIMEOUT constant.
REQ-036 MEM/WB storage SHALL be sub-module mem_wb_flopr (parameter WIDTH, async active-low reset, bubble input).

Verification
REQ-037 ALU op alu_out=0x10, dst=5, wreg=1 -> next edge result_ow32=0x10, dst 5, enable_wreg_ow=1, stall_o never high.
REQ-038 Load addr 0x20, ack same cycle, rdata 0xDEADBEEF -> stall_o=0; next edge result_ow32=0xDEADBEEF, enable_wreg_ow=1.
REQ-039 Store addr 0x40, data 0x55, ack after 3 cycles -> req/we high 4 cycles, stall_o high 3 cycles, 3 bubbles, then enable_wreg_ow=0.
REQ-040 Load addr 0x22 -> no dmem_req_o, mem_err_o=1 next edge, bubble.
REQ-041 Load with no ack, MEM_TIMEOUT=4 -> abort after 4 WAIT cycles, mem_err_o=1, state IDLE, stall_o drops.
REQ-042 reset_ni low during WAIT -> dmem_req_o, stall_o, all outputs 0 immediately; after release, a new ALU op completes normally.
